lora_frame_sequencer: RTL and testbench
=======================================

Name: lora_frame_sequencer

Overview:
- Controller that sequences one LoRa frame through the existing chirp modulator: preamble upchirps, two sync symbols, 2.25 downchirp SFD, then payload symbols.
- Payload symbols arrive on a valid/ready stream. The block drives the modulator's chirp reset, SF/BW select and symbol value/type, and advances one symbol per modulator symDone pulse.
- It sits between the packet source logic and the modulator in the 4 MHz divided-clock domain.
- It enforces an inter-frame gap before reporting done.

Parameters:
- GAP_CYCLES, 4000, idle cycles after the last symbol before done (1 ms at 4 MHz); must be at least 1.
- SYM_W, 12, width of symbol value bus (SF12 max).

Ports:
- clk  in  1  symbol-domain clock (divided 4 MHz clock)
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame request; cfg_* sampled on the same cycle
- abort  in  1  terminate current frame
- cfg_sf  in  3  0=SF7 .. 5=SF12; 6 and 7 are illegal
- cfg_bw  in  3  bandwidth select, passed through unchanged
- cfg_preamble_len  in  8  number of preamble upchirps, 1..255
- cfg_sync_word  in  8  LoRa sync word
- cfg_payload_len  in  8  number of payload symbols, 0..255
- pl_sym  in  SYM_W  payload symbol
- pl_valid  in  1  payload symbol valid
- pl_ready  out  1  payload symbol accepted this cycle
- sym_done  in  1  modulator end-of-symbol pulse
- chirp_rst  out  1  modulator reset; high = held idle
- sf_select  out  3  latched cfg_sf
- bw_select  out  3  latched cfg_bw
- sym_val  out  SYM_W  current symbol value
- sym_type  out  2  00 base upchirp, 01 data upchirp, 10 full downchirp, 11 quarter downchirp
- busy  out  1  frame in progress, including the gap
- done  out  1  one-cycle pulse at the end of a frame
- err_cfg  out  1  one-cycle pulse when a start is rejected
- err_underrun  out  1  one-cycle pulse when a frame aborts on underrun

Behaviour:
- Reset values: chirp_rst=1; all other outputs 0, i.e. busy, done, err_*, pl_ready, sym_val, sym_type, sf_select, bw_select.
- A reset mid-frame returns the block to IDLE on the same edge. It also discards the payload holding register.
- States: IDLE, PRE, SYNC1, SYNC2, SFD1, SFD2, SFDQ, PAY, GAP, ABORT.
- IDLE, on start:
  - If cfg_sf>5 or cfg_preamble_len==0: pulse err_cfg next cycle and stay in IDLE.
  - Otherwise: latch all cfg_*, drive chirp_rst=0, busy=1, enter PRE with sym_type=00, sym_val=0.
  - start is ignored while busy.
- Outputs are registered and change only on the cycle after sym_done, so symbol fields are stable across each symbol.
- Transitions, each taken on sym_done:
  - PRE counts cfg_preamble_len symbols, then goes to SYNC1.
  - SYNC1: type 01, sym_val = sync_word[7:4]*8.
  - SYNC2: type 01, sym_val = sync_word[3:0]*8.
  - SFD1 and SFD2: type 10.
  - SFDQ: type 11.
  - After SFDQ: go to PAY, or to GAP if cfg_payload_len==0.
- Payload buffering:
  - A one-entry holding register prefetches payload symbols.
  - pl_ready = busy && state not GAP/ABORT && holding empty && symbols-still-to-fetch>0.
  - A symbol transfers on pl_valid && pl_ready.
- Payload symbol output:
  - In PAY, sym_val = held symbol masked to (cfg_sf+7) LSBs; type 01.
  - The holding register empties when the symbol is loaded to the outputs.
  - Upper bits beyond the SF width are forced to 0.
- Entering PAY and advancing:
  - The first payload symbol is loaded on the sym_done that ends SFDQ.
  - Each later one loads on the sym_done ending the previous payload symbol.
  - The sym_done ending the last payload symbol goes to GAP.
- Underrun:
  - Condition: a payload symbol is needed on a sym_done but the holding register is empty. A transfer on the same cycle does not count.
  - Response: enter ABORT, pulse err_underrun, drive chirp_rst=1, and return to IDLE next cycle. done is not pulsed.
- abort, any non-IDLE state: ABORT next cycle. chirp_rst=1, busy clears on the IDLE entry, no done.
- abort has priority over a simultaneous sym_done.
- GAP:
  - chirp_rst=1, sym_type/sym_val return to 0.
  - Counts GAP_CYCLES cycles, then done pulses for one cycle as busy falls to 0 in the same cycle.
  - A start in the cycle done is high is ignored.
- sym_done in IDLE or GAP is ignored.
- The frame occupies cfg_preamble_len + 5 + cfg_payload_len sym_done pulses.

Test Plan:
- Nominal frame:
  - Stimulus: start with sf=0, bw=2, preamble=8, sync=0x34, payload=3 (symbols 0x05, 0x7F, 0xFFF), pl_valid always high.
  - Required response:
    - Types: 8×00, then 01 with values 0x18 and 0x20, then 10, 10, 11.
    - Payload: 01 with values 0x05, 0x7F, 0x7F (0xFFF masked to 7 bits).
    - Then chirp_rst=1, done after exactly 4000 cycles of GAP.
- Config reject:
  - Stimulus: start with cfg_sf=6; separately, start with preamble_len=0.
  - Required response: err_cfg pulses, busy stays 0, chirp_rst stays 1.
- Underrun:
  - Stimulus: payload=2; pl_valid drops after the first symbol and stays low through the second needed sym_done.
  - Required response: err_underrun pulses, chirp_rst=1, IDLE next cycle, no done.
- Abort:
  - Stimulus: abort asserted coincident with sym_done during SYNC2.
  - Required response: ABORT wins, no advance to SFD1, IDLE one cycle later, no done.
- Zero payload and busy start:
  - Stimulus: payload_len=0; a second start is asserted while busy.
  - Required response: SFDQ goes directly to GAP, pl_ready is never asserted, the second start is ignored, and a new start is accepted only after done.
- Reset mid-PAY:
  - Stimulus: rst asserted during PAY.
  - Required response: all outputs take reset values on that edge, and the holding register is cleared so a stale symbol does not appear in the next frame.

Source files
------------

// File: rtl/lora_frame_sequencer.sv
// rtl/lora_frame_sequencer.sv - sequences one LoRa frame (preamble, sync, SFD, payload, gap) through the chirp modulator
module lora_frame_sequencer #(
  parameter int GAP_CYCLES = 4000,
  parameter int SYM_W      = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [2:0]       i_cfg_sf,
  input  logic [2:0]       i_cfg_bw,
  input  logic [7:0]       i_cfg_preamble_len,
  input  logic [7:0]       i_cfg_sync_word,
  input  logic [7:0]       i_cfg_payload_len,
  input  logic [SYM_W-1:0] i_pl_sym,
  input  logic             i_pl_valid,
  output logic             o_pl_ready,
  input  logic             i_sym_done,
  output logic             o_chirp_rst,
  output logic [2:0]       o_sf_select,
  output logic [2:0]       o_bw_select,
  output logic [SYM_W-1:0] o_sym_val,
  output logic [1:0]       o_sym_type,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err_cfg,
  output logic             o_err_underrun
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SYNC1, S_SYNC2, S_SFD1, S_SFD2, S_SFDQ, S_PAY, S_GAP, S_ABORT
  } state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_sf, w_sf_nxt, r_bw, w_bw_nxt;
  logic [7:0]       r_pre_len, w_pre_len_nxt;
  logic [7:0]       r_sync, w_sync_nxt;
  logic [7:0]       r_pre_cnt, w_pre_cnt_nxt;
  logic [7:0]       r_fetch_left, w_fetch_left_nxt;
  logic [7:0]       r_pay_left, w_pay_left_nxt;
  logic [SYM_W-1:0] r_hold, w_hold_nxt;
  logic             r_hold_vld, w_hold_vld_nxt;
  logic [GW-1:0]    r_gap_cnt, w_gap_cnt_nxt;
  logic             r_chirp_rst, w_chirp_rst_nxt;
  logic [SYM_W-1:0] r_sym_val, w_sym_val_nxt;
  logic [1:0]       r_sym_type, w_sym_type_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err_cfg, w_err_cfg_nxt;
  logic             r_err_underrun, w_err_underrun_nxt;

  logic             w_pl_ready;
  logic             w_xfer;
  logic [3:0]       w_sf_bits;
  logic [SYM_W-1:0] w_mask;
  logic [SYM_W-1:0] w_pay_val;

  // Payload symbols are truncated to the SF width (SF7 -> 7 bits .. SF12 -> 12 bits)
  assign w_sf_bits = {1'b0, r_sf} + 4'd7;
  assign w_mask    = ~({SYM_W{1'b1}} << w_sf_bits);
  assign w_pay_val = r_hold & w_mask;

  // Prefetch only while the frame still needs symbols and the holding slot is free
  assign w_pl_ready = r_busy && (r_state != S_GAP) && (r_state != S_ABORT) &&
                      !r_hold_vld && (r_fetch_left != 8'd0);
  assign w_xfer     = w_pl_ready && i_pl_valid;

  // Next-state and next-output logic; symbol fields only move on sym_done
  always_comb begin
    w_state_nxt        = r_state;
    w_sf_nxt           = r_sf;
    w_bw_nxt           = r_bw;
    w_pre_len_nxt      = r_pre_len;
    w_sync_nxt         = r_sync;
    w_pre_cnt_nxt      = r_pre_cnt;
    w_fetch_left_nxt   = r_fetch_left;
    w_pay_left_nxt     = r_pay_left;
    w_hold_nxt         = r_hold;
    w_hold_vld_nxt     = r_hold_vld;
    w_gap_cnt_nxt      = r_gap_cnt;
    w_chirp_rst_nxt    = r_chirp_rst;
    w_sym_val_nxt      = r_sym_val;
    w_sym_type_nxt     = r_sym_type;
    w_busy_nxt         = r_busy;
    w_done_nxt         = 1'b0;
    w_err_cfg_nxt      = 1'b0;
    w_err_underrun_nxt = 1'b0;

    if (w_xfer) begin
      w_hold_nxt       = i_pl_sym;
      w_hold_vld_nxt   = 1'b1;
      w_fetch_left_nxt = r_fetch_left - 8'd1;
    end

    if (r_state == S_ABORT) begin
      w_state_nxt      = S_IDLE;
      w_busy_nxt       = 1'b0;
      w_hold_vld_nxt   = 1'b0;
      w_fetch_left_nxt = 8'd0;
    end else if ((r_state != S_IDLE) && i_abort) begin
      w_state_nxt     = S_ABORT;
      w_chirp_rst_nxt = 1'b1;
      w_sym_val_nxt   = '0;
      w_sym_type_nxt  = 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          // r_done blocks a start landing in the same cycle as the done pulse
          if (i_start && !r_done) begin
            if ((i_cfg_sf > 3'd5) || (i_cfg_preamble_len == 8'd0)) begin
              w_err_cfg_nxt = 1'b1;
            end else begin
              w_state_nxt      = S_PRE;
              w_sf_nxt         = i_cfg_sf;
              w_bw_nxt         = i_cfg_bw;
              w_pre_len_nxt    = i_cfg_preamble_len;
              w_sync_nxt       = i_cfg_sync_word;
              w_pre_cnt_nxt    = 8'd0;
              w_fetch_left_nxt = i_cfg_payload_len;
              w_pay_left_nxt   = i_cfg_payload_len;
              w_hold_vld_nxt   = 1'b0;
              w_chirp_rst_nxt  = 1'b0;
              w_busy_nxt       = 1'b1;
              w_sym_type_nxt   = 2'b00;
              w_sym_val_nxt    = '0;
            end
          end
        end
        S_PRE: begin
          if (i_sym_done) begin
            if (r_pre_cnt == (r_pre_len - 8'd1)) begin
              w_state_nxt    = S_SYNC1;
              w_sym_type_nxt = 2'b01;
              w_sym_val_nxt  = SYM_W'({r_sync[7:4], 3'b000});
            end else begin
              w_pre_cnt_nxt = r_pre_cnt + 8'd1;
            end
          end
        end
        S_SYNC1: begin
          if (i_sym_done) begin
            w_state_nxt    = S_SYNC2;
            w_sym_type_nxt = 2'b01;
            w_sym_val_nxt  = SYM_W'({r_sync[3:0], 3'b000});
          end
        end
        S_SYNC2: begin
          if (i_sym_done) begin
            w_state_nxt    = S_SFD1;
            w_sym_type_nxt = 2'b10;
            w_sym_val_nxt  = '0;
          end
        end
        S_SFD1: begin
          if (i_sym_done) begin
            w_state_nxt    = S_SFD2;
            w_sym_type_nxt = 2'b10;
          end
        end
        S_SFD2: begin
          if (i_sym_done) begin
            w_state_nxt    = S_SFDQ;
            w_sym_type_nxt = 2'b11;
          end
        end
        S_SFDQ, S_PAY: begin
          // r_pay_left counts payload symbols not yet put on the outputs
          if (i_sym_done) begin
            if (r_pay_left == 8'd0) begin
              w_state_nxt     = S_GAP;
              w_chirp_rst_nxt = 1'b1;
              w_sym_type_nxt  = 2'b00;
              w_sym_val_nxt   = '0;
              w_gap_cnt_nxt   = '0;
            end else if (r_hold_vld) begin
              w_state_nxt    = S_PAY;
              w_sym_type_nxt = 2'b01;
              w_sym_val_nxt  = w_pay_val;
              w_hold_vld_nxt = 1'b0;
              w_pay_left_nxt = r_pay_left - 8'd1;
            end else begin
              w_state_nxt        = S_ABORT;
              w_err_underrun_nxt = 1'b1;
              w_chirp_rst_nxt    = 1'b1;
              w_sym_type_nxt     = 2'b00;
              w_sym_val_nxt      = '0;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; reset also discards the payload holding slot
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_sf           <= 3'd0;
      r_bw           <= 3'd0;
      r_pre_len      <= 8'd0;
      r_sync         <= 8'd0;
      r_pre_cnt      <= 8'd0;
      r_fetch_left   <= 8'd0;
      r_pay_left     <= 8'd0;
      r_hold         <= '0;
      r_hold_vld     <= 1'b0;
      r_gap_cnt      <= '0;
      r_chirp_rst    <= 1'b1;
      r_sym_val      <= '0;
      r_sym_type     <= 2'b00;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err_cfg      <= 1'b0;
      r_err_underrun <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_sf           <= w_sf_nxt;
      r_bw           <= w_bw_nxt;
      r_pre_len      <= w_pre_len_nxt;
      r_sync         <= w_sync_nxt;
      r_pre_cnt      <= w_pre_cnt_nxt;
      r_fetch_left   <= w_fetch_left_nxt;
      r_pay_left     <= w_pay_left_nxt;
      r_hold         <= w_hold_nxt;
      r_hold_vld     <= w_hold_vld_nxt;
      r_gap_cnt      <= w_gap_cnt_nxt;
      r_chirp_rst    <= w_chirp_rst_nxt;
      r_sym_val      <= w_sym_val_nxt;
      r_sym_type     <= w_sym_type_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
      r_err_cfg      <= w_err_cfg_nxt;
      r_err_underrun <= w_err_underrun_nxt;
    end
  end

  assign o_pl_ready     = w_pl_ready;
  assign o_chirp_rst    = r_chirp_rst;
  assign o_sf_select    = r_sf;
  assign o_bw_select    = r_bw;
  assign o_sym_val      = r_sym_val;
  assign o_sym_type     = r_sym_type;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err_cfg      = r_err_cfg;
  assign o_err_underrun = r_err_underrun;

endmodule

// File: tb/tb_lora_frame_sequencer.sv
// tb/tb_lora_frame_sequencer.sv - self-checking bench for lora_frame_sequencer
module tb_lora_frame_sequencer;

  localparam int GAP = 4000;
  localparam int SW  = 12;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [2:0]    i_cfg_sf = 3'd0;
  logic [2:0]    i_cfg_bw = 3'd0;
  logic [7:0]    i_cfg_preamble_len = 8'd0;
  logic [7:0]    i_cfg_sync_word = 8'd0;
  logic [7:0]    i_cfg_payload_len = 8'd0;
  logic [SW-1:0] i_pl_sym = '0;
  logic          i_pl_valid = 1'b0;
  logic          o_pl_ready;
  logic          i_sym_done = 1'b0;
  logic          o_chirp_rst;
  logic [2:0]    o_sf_select;
  logic [2:0]    o_bw_select;
  logic [SW-1:0] o_sym_val;
  logic [1:0]    o_sym_type;
  logic          o_busy;
  logic          o_done;
  logic          o_err_cfg;
  logic          o_err_underrun;

  lora_frame_sequencer #(.GAP_CYCLES(GAP), .SYM_W(SW)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_start            (i_start),
    .i_abort            (i_abort),
    .i_cfg_sf           (i_cfg_sf),
    .i_cfg_bw           (i_cfg_bw),
    .i_cfg_preamble_len (i_cfg_preamble_len),
    .i_cfg_sync_word    (i_cfg_sync_word),
    .i_cfg_payload_len  (i_cfg_payload_len),
    .i_pl_sym           (i_pl_sym),
    .i_pl_valid         (i_pl_valid),
    .o_pl_ready         (o_pl_ready),
    .i_sym_done         (i_sym_done),
    .o_chirp_rst        (o_chirp_rst),
    .o_sf_select        (o_sf_select),
    .o_bw_select        (o_bw_select),
    .o_sym_val          (o_sym_val),
    .o_sym_type         (o_sym_type),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_err_cfg          (o_err_cfg),
    .o_err_underrun     (o_err_underrun)
  );

  always #5 i_clk = ~i_clk;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [SW-1:0] pl_q[$];
  int            pl_idx = 0;
  bit            ready_seen = 1'b0;
  int            exp_t[$];
  int            exp_v[$];
  int            exp_i = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive this cycle's inputs, move past the edge, sample point is 1ns after it
  task automatic cyc(input logic sd);
    logic xfer;
    i_sym_done = sd;
    if (pl_idx < pl_q.size()) begin
      i_pl_valid = 1'b1;
      i_pl_sym   = pl_q[pl_idx];
    end else begin
      i_pl_valid = 1'b0;
      i_pl_sym   = SW'($urandom);
    end
    if (o_pl_ready === 1'b1) ready_seen = 1'b1;
    xfer = i_pl_valid && (o_pl_ready === 1'b1);
    @(posedge i_clk);
    #1;
    if (xfer) pl_idx++;
    i_sym_done = 1'b0;
    i_start    = 1'b0;
    i_abort    = 1'b0;
  endtask

  // Reference symbol list of a whole frame, straight from the frame format
  task automatic build_expect(input int pre, input int sync, input int sf, input int pay);
    int v;
    exp_t.delete();
    exp_v.delete();
    for (int i = 0; i < pre; i++) begin exp_t.push_back(0); exp_v.push_back(0); end
    exp_t.push_back(1); exp_v.push_back((sync / 16) * 8);
    exp_t.push_back(1); exp_v.push_back((sync % 16) * 8);
    exp_t.push_back(2); exp_v.push_back(0);
    exp_t.push_back(2); exp_v.push_back(0);
    exp_t.push_back(3); exp_v.push_back(0);
    for (int i = 0; i < pay; i++) begin
      v = (i < pl_q.size()) ? int'(pl_q[i]) : 0;
      exp_t.push_back(1);
      exp_v.push_back(v % (1 << (sf + 7)));
    end
    exp_i = 0;
  endtask

  task automatic start_frame(input string tag, input int pre, input int sf, input int bw,
                             input int sync, input int pay);
    pl_idx             = 0;
    i_cfg_sf           = 3'(sf);
    i_cfg_bw           = 3'(bw);
    i_cfg_preamble_len = 8'(pre);
    i_cfg_sync_word    = 8'(sync);
    i_cfg_payload_len  = 8'(pay);
    i_start            = 1'b1;
    cyc(1'b0);
    check_eq({tag, "_busy"}, 32'(o_busy), 1);
    check_eq({tag, "_chirp_rst"}, 32'(o_chirp_rst), 0);
    check_eq({tag, "_sf_sel"}, 32'(o_sf_select), sf);
    check_eq({tag, "_bw_sel"}, 32'(o_bw_select), bw);
    check_eq({tag, "_err_cfg"}, 32'(o_err_cfg), 0);
    build_expect(pre, sync, sf, pay);
  endtask

  // Play n symbols: fields must hold steady until the closing sym_done
  task automatic play_syms(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(1, 3)) cyc(1'b0);
      if (exp_i < exp_t.size()) begin
        check_eq($sformatf("%s_type%0d", tag, exp_i), 32'(o_sym_type), exp_t[exp_i]);
        check_eq($sformatf("%s_val%0d", tag, exp_i), 32'(o_sym_val), exp_v[exp_i]);
        check_eq($sformatf("%s_crst%0d", tag, exp_i), 32'(o_chirp_rst), 0);
      end
      cyc(1'b1);
      exp_i++;
    end
  endtask

  task automatic finish_gap(input string tag, input bit start_on_done);
    int cnt;
    check_eq({tag, "_gap_crst"}, 32'(o_chirp_rst), 1);
    check_eq({tag, "_gap_type"}, 32'(o_sym_type), 0);
    check_eq({tag, "_gap_val"}, 32'(o_sym_val), 0);
    check_eq({tag, "_gap_busy"}, 32'(o_busy), 1);
    cnt = 0;
    while ((o_done !== 1'b1) && (cnt < GAP + 20)) begin
      cyc(1'b0);
      cnt++;
    end
    check_eq({tag, "_gap_len"}, cnt, GAP);
    check_eq({tag, "_done_busy"}, 32'(o_busy), 0);
    if (start_on_done) i_start = 1'b1;
    cyc(1'b0);
    check_eq({tag, "_done_1cyc"}, 32'(o_done), 0);
    if (start_on_done) check_eq({tag, "_start_on_done"}, 32'(o_busy), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_crst"}, 32'(o_chirp_rst), 1);
    check_eq({tag, "_busy"}, 32'(o_busy), 0);
    check_eq({tag, "_done"}, 32'(o_done), 0);
    check_eq({tag, "_errc"}, 32'(o_err_cfg), 0);
    check_eq({tag, "_erru"}, 32'(o_err_underrun), 0);
    check_eq({tag, "_rdy"}, 32'(o_pl_ready), 0);
    check_eq({tag, "_val"}, 32'(o_sym_val), 0);
    check_eq({tag, "_type"}, 32'(o_sym_type), 0);
    check_eq({tag, "_sf"}, 32'(o_sf_select), 0);
    check_eq({tag, "_bw"}, 32'(o_bw_select), 0);
  endtask

  initial begin
    int pre, sf, bw, sync, pay;

    // Reset state
    i_rst = 1'b1;
    repeat (3) cyc(1'b0);
    check_reset_vals("rst");
    i_rst = 1'b0;
    cyc(1'b0);

    // Nominal frame
    pl_q = '{12'h005, 12'h07F, 12'hFFF};
    start_frame("nom", 8, 0, 2, 8'h34, 3);
    play_syms("nom", exp_t.size());
    finish_gap("nom", 1'b0);

    // Illegal SF and zero preamble are rejected
    i_cfg_sf = 3'd6; i_cfg_preamble_len = 8'd4; i_start = 1'b1;
    cyc(1'b0);
    check_eq("rej_sf_err", 32'(o_err_cfg), 1);
    check_eq("rej_sf_busy", 32'(o_busy), 0);
    check_eq("rej_sf_crst", 32'(o_chirp_rst), 1);
    cyc(1'b0);
    check_eq("rej_sf_pulse", 32'(o_err_cfg), 0);
    check_eq("rej_sf_busy2", 32'(o_busy), 0);
    i_cfg_sf = 3'd2; i_cfg_preamble_len = 8'd0; i_start = 1'b1;
    cyc(1'b0);
    check_eq("rej_pre_err", 32'(o_err_cfg), 1);
    check_eq("rej_pre_busy", 32'(o_busy), 0);
    check_eq("rej_pre_crst", 32'(o_chirp_rst), 1);
    cyc(1'b0);
    check_eq("rej_pre_pulse", 32'(o_err_cfg), 0);

    // Underrun on the second payload symbol
    pl_q = '{12'h123};
    start_frame("und", 2, 5, 1, 8'h5A, 2);
    play_syms("und", 2 + 5 + 1);
    check_eq("und_err", 32'(o_err_underrun), 1);
    check_eq("und_crst", 32'(o_chirp_rst), 1);
    check_eq("und_done", 32'(o_done), 0);
    cyc(1'b0);
    check_eq("und_idle_busy", 32'(o_busy), 0);
    check_eq("und_pulse", 32'(o_err_underrun), 0);
    check_eq("und_done2", 32'(o_done), 0);

    // Abort coincident with sym_done in SYNC2
    pl_q.delete();
    start_frame("abt", 1, 1, 3, 8'hA5, 0);
    play_syms("abt", 2);
    check_eq("abt_sync2_type", 32'(o_sym_type), 1);
    check_eq("abt_sync2_val", 32'(o_sym_val), 40);
    i_abort = 1'b1;
    cyc(1'b1);
    check_eq("abt_crst", 32'(o_chirp_rst), 1);
    check_eq("abt_no_sfd", 32'(o_sym_type == 2'b10), 0);
    check_eq("abt_busy", 32'(o_busy), 1);
    check_eq("abt_done", 32'(o_done), 0);
    cyc(1'b0);
    check_eq("abt_idle_busy", 32'(o_busy), 0);
    check_eq("abt_done2", 32'(o_done), 0);

    // Zero payload, start while busy ignored, start on done ignored
    pl_q = '{12'h111};
    ready_seen = 1'b0;
    start_frame("zp", 3, 2, 1, 8'h12, 0);
    i_cfg_sf = 3'd4; i_cfg_preamble_len = 8'd9; i_start = 1'b1;
    cyc(1'b0);
    check_eq("zp_restart_sf", 32'(o_sf_select), 2);
    check_eq("zp_restart_busy", 32'(o_busy), 1);
    play_syms("zp", exp_t.size());
    finish_gap("zp", 1'b1);
    check_eq("zp_no_ready", 32'(ready_seen), 0);
    pl_q.delete();
    start_frame("zp2", 2, 4, 0, 8'h77, 0);
    i_abort = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    check_eq("zp2_abort_busy", 32'(o_busy), 0);

    // Reset mid-PAY, then make sure the stale prefetched symbol is gone
    pl_q = '{12'h0AB, 12'h0CD, 12'h0EF};
    start_frame("rp", 1, 5, 6, 8'h21, 3);
    play_syms("rp", 1 + 5);
    repeat (3) cyc(1'b0);
    check_eq("rp_pay0", 32'(o_sym_val), 12'h0AB);
    i_rst = 1'b1;
    cyc(1'b0);
    check_reset_vals("rp_rst");
    i_rst = 1'b0;
    cyc(1'b0);
    pl_q = '{12'h3C5};
    start_frame("rp2", 1, 5, 6, 8'h21, 1);
    play_syms("rp2", exp_t.size());
    finish_gap("rp2", 1'b0);

    // Randomized frames
    for (int r = 0; r < 5; r++) begin
      sf   = $urandom_range(0, 5);
      bw   = $urandom_range(0, 7);
      pre  = $urandom_range(1, 10);
      sync = $urandom_range(0, 255);
      pay  = $urandom_range(0, 6);
      pl_q.delete();
      for (int i = 0; i < pay; i++) pl_q.push_back(SW'($urandom));
      start_frame($sformatf("rnd%0d", r), pre, sf, bw, sync, pay);
      play_syms($sformatf("rnd%0d", r), exp_t.size());
      finish_gap($sformatf("rnd%0d", r), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
